// File: rtl/fsm_out_wrmem_if.sv
// Stream-port and memory-write bundle for fsm_out_wrmem.
// The slave modport is the controller; the master modport is its environment.
interface fsm_out_wrmem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 16
) ();
  logic              start;
  logic [CNT_W-1:0]  size;
  logic [ADDR_W-1:0] base_addr;
  logic              abort;
  logic              in_send;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              mem_full;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              count;
  logic              burst_done;
  logic              done;
  logic              busy;

  modport slave (
    input  start, size, base_addr, abort, in_send, in_data, mem_full,
    output in_rdy, mem_write, mem_addr, mem_data, count, burst_done, done, busy
  );

  modport master (
    output start, size, base_addr, abort, in_send, in_data, mem_full,
    input  in_rdy, mem_write, mem_addr, mem_data, count, burst_done, done, busy
  );
endinterface

// File: rtl/fsm_out_wrmem.sv
// Stream-to-memory write controller: accepts send/rdy stream words and writes them to
// incrementing addresses in bursts separated by one idle cycle, ending after a word count.
module fsm_out_wrmem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned BURST_LEN = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  fsm_out_wrmem_if.slave bus
);

  localparam int unsigned BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRecv = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_remaining;
  logic [ADDR_W-1:0] r_addr;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_burst_done;
  logic              r_done;

  logic w_in_rdy;
  logic w_xfer;

  // Abort masks ready so a word offered in the abort cycle stays with the producer.
  assign w_in_rdy = (r_state == StRecv) && !bus.mem_full && !bus.abort;
  assign w_xfer   = bus.in_send && w_in_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_remaining  <= '0;
      r_addr       <= '0;
      r_bcnt       <= '0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_burst_done <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_mem_write  <= w_xfer;
      r_burst_done <= 1'b0;
      r_done       <= 1'b0;
      if (w_xfer) begin
        r_mem_addr  <= r_addr;
        r_mem_data  <= bus.in_data;
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
        r_bcnt      <= r_bcnt + BCNT_W'(1);
      end
      if (bus.abort && (r_state != StIdle)) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (bus.start) begin
              r_remaining <= bus.size;
              r_addr      <= bus.base_addr;
              r_bcnt      <= '0;
              r_state     <= (bus.size != '0) ? StRecv : StDone;
            end
          end
          StRecv: begin
            // The last word of the transfer wins over a burst boundary.
            if (w_xfer) begin
              if (r_remaining == CNT_W'(1)) begin
                r_state <= StDone;
              end else if (r_bcnt == BCNT_LAST) begin
                r_bcnt       <= '0;
                r_state      <= StGap;
                r_burst_done <= 1'b1;
              end
            end
          end
          StGap: begin
            r_state <= StRecv;
          end
          StDone: begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_rdy     = w_in_rdy;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign bus.count      = r_mem_write;
  assign bus.burst_done = r_burst_done;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_fsm_out_wrmem.sv
// Directed bench for fsm_out_wrmem: bursts, stalls, address wrap, zero size, abort, reset.
module tb_fsm_out_wrmem;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 16;
  localparam int unsigned BL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsm_out_wrmem_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  fsm_out_wrmem #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .CNT_W    (CW),
    .BURST_LEN(BL)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cnt_err  = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          bd_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      wr_addr.push_back(32'(bus.mem_addr));
      wr_data.push_back(bus.mem_data);
      wr_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
    if (bus.burst_done === 1'b1) bd_cyc.push_back(cyc);
    if (bus.count !== bus.mem_write) cnt_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qw(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic clear_log();
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    bd_cyc.delete();
  endtask

  task automatic start_pulse(input logic [CW-1:0] sz, input logic [AW-1:0] ba, output int t0);
    @(negedge clk);
    t0            = cyc;
    bus.start     = 1'b1;
    bus.size      = sz;
    bus.base_addr = ba;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Producer holds data until accepted; returns the number of cycles it saw in_rdy low.
  task automatic stream(input int n, input logic [31:0] d0, input logic [31:0] full_mask,
                        input int abort_at, input int budget, output int rdy_low);
    int   sent;
    logic hs;
    sent    = 0;
    rdy_low = 0;
    for (int it = 0; it < budget && sent < n; it++) begin
      @(negedge clk);
      bus.in_send  = 1'b1;
      bus.in_data  = d0 + 32'(sent);
      bus.mem_full = (it < 32) ? full_mask[it] : 1'b0;
      bus.abort    = (it == abort_at);
      #1;
      hs = bus.in_rdy;
      if (!hs) rdy_low++;
      @(posedge clk);
      #1;
      if (hs) sent++;
      if (it == abort_at) break;
    end
    bus.in_send  = 1'b0;
    bus.mem_full = 1'b0;
    bus.abort    = 1'b0;
  endtask

  initial begin
    int          t0;
    int          rl;
    logic [31:0] t4_exp[4];
    t4_exp = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.size      = '0;
    bus.base_addr = '0;
    bus.abort     = 1'b0;
    bus.in_send   = 1'b0;
    bus.in_data   = '0;
    bus.mem_full  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst mem_write",  32'(bus.mem_write),  32'h0);
    chk("rst mem_addr",   32'(bus.mem_addr),   32'h0);
    chk("rst mem_data",   bus.mem_data,        32'h0);
    chk("rst count",      32'(bus.count),      32'h0);
    chk("rst burst_done", 32'(bus.burst_done), 32'h0);
    chk("rst done",       32'(bus.done),       32'h0);
    chk("rst busy",       32'(bus.busy),       32'h0);
    chk("rst in_rdy",     32'(bus.in_rdy),     32'h0);
    rst = 1'b0;

    // T1: 3 words from 0x010, continuous stream
    clear_log();
    start_pulse(16'd3, 12'h010, t0);
    chk("t1 busy", 32'(bus.busy), 32'h1);
    stream(3, 32'hA0, 32'h0, -1, 20, rl);
    repeat (4) @(negedge clk);
    chk("t1 nwr", 32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1 addr%0d", i), qw(wr_addr, i), 32'h010 + 32'(i));
      chk($sformatf("t1 data%0d", i), qw(wr_data, i), 32'hA0 + 32'(i));
    end
    chk("t1 back2back", 32'(qi(wr_cyc, 2) - qi(wr_cyc, 0)), 32'd2);
    chk("t1 ndone", 32'(done_cyc.size()), 32'd1);
    chk("t1 done time", 32'(qi(done_cyc, 0)), 32'(qi(wr_cyc, 2) + 1));
    chk("t1 nburst", 32'(bd_cyc.size()), 32'd0);
    chk("t1 rdy_low", 32'(rl), 32'd0);
    chk("t1 busy end", 32'(bus.busy), 32'h0);

    // T2: 10 words, bursts of 4 -> 4,4,2 with one gap after words 4 and 8
    clear_log();
    start_pulse(16'd10, 12'h100, t0);
    stream(10, 32'hB0, 32'h0, -1, 40, rl);
    repeat (4) @(negedge clk);
    chk("t2 nwr", 32'(wr_addr.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2 addr%0d", i), qw(wr_addr, i), 32'h100 + 32'(i));
      chk($sformatf("t2 data%0d", i), qw(wr_data, i), 32'hB0 + 32'(i));
    end
    chk("t2 gap1", 32'(qi(wr_cyc, 4) - qi(wr_cyc, 3)), 32'd2);
    chk("t2 gap2", 32'(qi(wr_cyc, 8) - qi(wr_cyc, 7)), 32'd2);
    chk("t2 rdy_low", 32'(rl), 32'd2);
    chk("t2 nburst", 32'(bd_cyc.size()), 32'd2);
    chk("t2 burst1 time", 32'(qi(bd_cyc, 0)), 32'(qi(wr_cyc, 3)));
    chk("t2 burst2 time", 32'(qi(bd_cyc, 1)), 32'(qi(wr_cyc, 7)));
    chk("t2 ndone", 32'(done_cyc.size()), 32'd1);
    chk("t2 done time", 32'(qi(done_cyc, 0)), 32'(qi(wr_cyc, 9) + 1));

    // T3: 3 words, mem_full on stream cycles 1..3
    clear_log();
    start_pulse(16'd3, 12'h020, t0);
    stream(3, 32'hC0, 32'b1110, -1, 20, rl);
    repeat (4) @(negedge clk);
    chk("t3 nwr", 32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3 addr%0d", i), qw(wr_addr, i), 32'h020 + 32'(i));
      chk($sformatf("t3 data%0d", i), qw(wr_data, i), 32'hC0 + 32'(i));
    end
    chk("t3 stall gap", 32'(qi(wr_cyc, 1) - qi(wr_cyc, 0)), 32'd4);
    chk("t3 rdy_low", 32'(rl), 32'd3);
    chk("t3 ndone", 32'(done_cyc.size()), 32'd1);

    // T4: address wrap; last word also ends a burst -> no gap, no burst_done
    clear_log();
    start_pulse(16'd4, 12'hFFE, t0);
    stream(4, 32'hD0, 32'h0, -1, 20, rl);
    repeat (4) @(negedge clk);
    chk("t4 nwr", 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4 addr%0d", i), qw(wr_addr, i), t4_exp[i]);
    end
    chk("t4 nburst", 32'(bd_cyc.size()), 32'd0);
    chk("t4 ndone", 32'(done_cyc.size()), 32'd1);
    chk("t4 done time", 32'(qi(done_cyc, 0)), 32'(qi(wr_cyc, 3) + 1));

    // T5: size 0, plus a second start presented while in DONE
    clear_log();
    @(negedge clk);
    t0            = cyc;
    bus.start     = 1'b1;
    bus.size      = 16'd0;
    bus.base_addr = 12'h200;
    @(negedge clk);
    chk("t5 busy", 32'(bus.busy), 32'h1);
    bus.size      = 16'd2;
    bus.base_addr = 12'h300;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5 nwr", 32'(wr_addr.size()), 32'd0);
    chk("t5 ndone", 32'(done_cyc.size()), 32'd1);
    chk("t5 done time", 32'(qi(done_cyc, 0)), 32'(t0 + 2));
    chk("t5 busy end", 32'(bus.busy), 32'h0);

    // T6: abort after 2 of 6 words
    clear_log();
    start_pulse(16'd6, 12'h040, t0);
    stream(6, 32'hE0, 32'h0, 2, 20, rl);
    chk("t6 busy after abort", 32'(bus.busy), 32'h0);
    chk("t6 mem_write after abort", 32'(bus.mem_write), 32'h0);
    repeat (4) @(negedge clk);
    chk("t6 nwr", 32'(wr_addr.size()), 32'd2);
    chk("t6 data1", qw(wr_data, 1), 32'hE1);
    chk("t6 ndone", 32'(done_cyc.size()), 32'd0);

    // Asynchronous reset in the middle of RECV
    clear_log();
    start_pulse(16'd6, 12'h080, t0);
    stream(2, 32'hF0, 32'h0, -1, 10, rl);
    chk("ar mem_write before", 32'(bus.mem_write), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar mem_write", 32'(bus.mem_write), 32'h0);
    chk("ar mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("ar mem_data",  bus.mem_data,       32'h0);
    chk("ar busy",      32'(bus.busy),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("ar busy after", 32'(bus.busy), 32'h0);
    chk("ar ndone", 32'(done_cyc.size()), 32'd0);
    chk("count tracks mem_write", 32'(cnt_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
